// File: rtl/psys_route_pkg.sv
// psys_route_pkg: shared FSM encoding and index helpers for the stream routing blocks.
// Slice payloads are packed as {tid, tlast, tdata}.
package psys_route_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction
endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: two-entry register slice; s_tready depends only on local occupancy.
module axis_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);
    logic [1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic push, pop;
    always_comb begin
        s_tready = cnt_q != 2'd2;
        m_tvalid = cnt_q != 2'd0;
        m_tdata = head_q;
        push = s_tvalid & s_tready;
        pop = m_tvalid & m_tready;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        // head is the oldest beat; a new beat lands in head only when it becomes the oldest
        head_d = (pop && cnt_q == 2'd2) ? tail_q :
                 (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? s_tdata : head_q;
        tail_d = (push && !pop && cnt_q == 2'd1) ? s_tdata : tail_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: packet-aware round-robin mux of NUM_IN AXI-Stream inputs onto one sliced output.
module stream_rr_arbiter
    import psys_route_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int DWIDTH = 32,
    parameter int MAX_BURST = 16,
    localparam int IDW = clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DWIDTH-1:0] s_in_tdata,
    input  logic [NUM_IN-1:0]        s_in_tvalid,
    input  logic [NUM_IN-1:0]        s_in_tlast,
    output logic [NUM_IN-1:0]        s_in_tready,
    output logic [DWIDTH-1:0]        m_out_tdata,
    output logic                     m_out_tvalid,
    output logic                     m_out_tlast,
    output logic [IDW-1:0]           m_out_tid,
    input  logic                     m_out_tready,
    output logic [IDW-1:0]           grant_idx,
    output logic                     busy
);
    localparam int PW = IDW + 1 + DWIDTH;
    localparam logic [7:0] CAP = 8'(MAX_BURST == 0 ? 0 : MAX_BURST - 1);
    state_e state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_idx_q, grant_idx_d, pick, cand;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic [DWIDTH-1:0] g_data;
    logic req, acc, sl_ready, seg_last, seg_end;
    logic [PW-1:0] sl_in, sl_out;
    always_comb begin
        // rotate by rr_ptr, find first requester, map back to an absolute index
        pick = rr_ptr_q;
        cand = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = IDW'(wrap_add(int'(rr_ptr_q), k, NUM_IN));
            if (s_in_tvalid[cand]) pick = cand;
        end
        g_data = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (grant_idx_q == IDW'(i)) g_data = s_in_tdata[i*DWIDTH +: DWIDTH];
        busy = state_q == ST_XFER;
        req = busy & s_in_tvalid[grant_idx_q];
        acc = req & sl_ready;
        seg_last = s_in_tlast[grant_idx_q] | ((MAX_BURST != 0) && beat_cnt_q == CAP);
        seg_end = acc & seg_last;
        s_in_tready = busy ? NUM_IN'(sl_ready) << grant_idx_q : '0;
        sl_in = {grant_idx_q, seg_last, g_data};
        grant_idx = grant_idx_q;
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        beat_cnt_d = beat_cnt_q;
        if (!busy && |s_in_tvalid) begin
            state_d = ST_XFER;
            grant_idx_d = pick;
            beat_cnt_d = '0;
        end else if (seg_end) begin
            state_d = ST_IDLE;
            rr_ptr_d = IDW'(wrap_add(int'(grant_idx_q), 1, NUM_IN));
            beat_cnt_d = '0;
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_idx_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
    axis_skid_buf #(.WIDTH(PW)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (sl_in),
        .s_tvalid (req),
        .s_tready (sl_ready),
        .m_tdata  (sl_out),
        .m_tvalid (m_out_tvalid),
        .m_tready (m_out_tready)
    );
    assign {m_out_tid, m_out_tlast, m_out_tdata} = sl_out;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: randomized traffic against a packet-level round-robin model.
module tb_stream_rr_arbiter;
    localparam int N = 4, W = 32, MB = 4, IW = 2;
    logic clk = 0, rst = 1;
    logic [N*W-1:0] s_in_tdata;
    logic [N-1:0] s_in_tvalid, s_in_tlast, s_in_tready;
    logic [W-1:0] m_out_tdata;
    logic m_out_tvalid, m_out_tlast, m_out_tready;
    logic [IW-1:0] m_out_tid, grant_idx;
    logic busy;

    always #5 clk = ~clk;

    stream_rr_arbiter #(.NUM_IN(N), .DWIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .s_in_tdata(s_in_tdata), .s_in_tvalid(s_in_tvalid),
        .s_in_tlast(s_in_tlast), .s_in_tready(s_in_tready), .m_out_tdata(m_out_tdata),
        .m_out_tvalid(m_out_tvalid), .m_out_tlast(m_out_tlast), .m_out_tid(m_out_tid),
        .m_out_tready(m_out_tready), .grant_idx(grant_idx), .busy(busy)
    );

    int vec = 0, errs = 0;
    logic [W-1:0] sd [N][64];
    logic sl [N][64];
    int sn [N], sp [N], seg [N], hold [N];
    logic [W+IW:0] exp_q [$], obs_q [$];
    logic [W+IW:0] cur, e, prev_beat;
    bit prev_stall = 0, run_en = 0, drop;
    int model_ptr = 0, rdy_pct = 100, gap_pct = 0;

    // Source drivers and output scoreboard; inputs change on the falling edge.
    always @(negedge clk) if (run_en) begin
        m_out_tready = $urandom_range(99) < rdy_pct;
        for (int i = 0; i < N; i++) begin
            drop = seg[i] != 0 && (hold[i] > 0 || $urandom_range(99) < gap_pct);
            if (seg[i] != 0 && hold[i] > 0) hold[i]--;
            s_in_tvalid[i] = sp[i] < sn[i] && !drop;
            s_in_tdata[i*W +: W] = sd[i][sp[i] & 63];
            s_in_tlast[i] = sl[i][sp[i] & 63];
        end
        #1;
        cur = {m_out_tid, m_out_tlast, m_out_tdata};
        vec++;
        if (!$onehot0(s_in_tready)) begin
            errs++; $display("FAIL ready_onehot: s_in_tready=%b, required at most one bit set", s_in_tready);
        end
        if (prev_stall) begin
            vec++;
            if (!m_out_tvalid || cur !== prev_beat) begin
                errs++; $display("FAIL stall_stable: valid=%b beat=%h, required valid=1 beat=%h", m_out_tvalid, cur, prev_beat);
            end
        end
        if (m_out_tvalid && m_out_tready) begin
            vec++;
            obs_q.push_back(cur);
            if (exp_q.size() == 0) begin
                errs++; $display("FAIL scoreboard: got beat %h, required no beat", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin errs++; $display("FAIL scoreboard: got %h, required %h", cur, e); end
            end
        end
        prev_stall = m_out_tvalid && !m_out_tready;
        prev_beat = cur;
        for (int i = 0; i < N; i++) if (s_in_tvalid[i] && s_in_tready[i]) begin
            seg[i] = (sl[i][sp[i] & 63] || seg[i] == MB - 1) ? 0 : seg[i] + 1;
            sp[i]++;
        end
    end

    // Packet-level arbitration: every input holding data is requesting at each decision.
    function automatic void build_expected();
        int pos [N];
        int g, c;
        bit last;
        for (int i = 0; i < N; i++) pos[i] = sp[i];
        forever begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && pos[(model_ptr + k) % N] < sn[(model_ptr + k) % N]) g = (model_ptr + k) % N;
            if (g < 0) break;
            c = 0;
            do begin
                last = sl[g][pos[g]];
                c++;
                exp_q.push_back({IW'(g), last || c == MB, sd[g][pos[g]]});
                pos[g]++;
            end while (!last && c < MB);
            model_ptr = (g + 1) % N;
        end
    endfunction

    function automatic void clear_state();
        for (int i = 0; i < N; i++) begin sn[i] = 0; sp[i] = 0; seg[i] = 0; hold[i] = 0; end
        exp_q.delete();
        obs_q.delete();
        prev_stall = 0;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (sp[i] < sn[i]) return 1;
        return 0;
    endfunction

    task automatic add_pkt(input int i, input int len, input logic [W-1:0] base, input bit rnd);
        for (int b = 0; b < len; b++) begin
            sd[i][sn[i]] = rnd ? W'($urandom) : base + W'(b);
            sl[i][sn[i]] = b == len - 1;
            sn[i]++;
        end
    endtask

    task automatic start();
        build_expected();
        @(posedge clk);
        #1 run_en = 1;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || pending()) && c < 3000) begin @(negedge clk); c++; end
        #3;
        run_en = 0;
        s_in_tvalid = '0;
        m_out_tready = 1;
        vec++;
        if (exp_q.size() != 0) begin
            errs++; $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
        vec++;
        if (m_out_tvalid !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL %s_idle: m_out_tvalid=%b busy=%b, required 0 0", name, m_out_tvalid, busy);
        end
    endtask

    task automatic do_reset();
        run_en = 0;
        s_in_tvalid = '0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_ptr = 0;
        clear_state();
    endtask

    task automatic test_reset();
        rst = 1; m_out_tready = 1; s_in_tvalid = '1; s_in_tlast = '1;
        for (int i = 0; i < N; i++) s_in_tdata[i*W +: W] = W'(i + 5);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec++;
            if (s_in_tready !== '0 || m_out_tvalid !== 1'b0 || busy !== 1'b0 || m_out_tdata !== '0 || m_out_tid !== '0 || m_out_tlast !== 1'b0) begin
                errs++; $display("FAIL reset_hold: ready=%b valid=%b busy=%b data=%h, required 0 0 0 0", s_in_tready, m_out_tvalid, busy, m_out_tdata);
            end
        end
        rst = 0;
        @(negedge clk);
        vec++;
        if (busy !== 1'b1 || grant_idx !== 2'd0 || s_in_tready !== 4'b0001) begin
            errs++; $display("FAIL reset_first_grant: busy=%b grant=%0d ready=%b, required 1 0 0001", busy, grant_idx, s_in_tready);
        end
        @(negedge clk);
        s_in_tvalid = '0;
        vec++;
        if (m_out_tvalid !== 1'b1 || m_out_tdata !== 32'd5 || m_out_tid !== 2'd0 || m_out_tlast !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL reset_first_beat: v=%b d=%h tid=%0d last=%b busy=%b, required 1 5 0 1 0", m_out_tvalid, m_out_tdata, m_out_tid, m_out_tlast, busy);
        end
        @(negedge clk);
        vec++;
        if (m_out_tvalid !== 1'b0) begin errs++; $display("FAIL reset_pop: m_out_tvalid=%b, required 0", m_out_tvalid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        rdy_pct = 100; gap_pct = 0;
        for (int i = 0; i < N; i++) add_pkt(i, 2, W'(i * 16), 0);
        start();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk); #2;
            vec++;
            if (busy !== (k % 3 != 0)) begin errs++; $display("FAIL rr_idle_gap: cycle %0d busy=%b, required %0d", k, busy, k % 3 != 0); end
        end
        drain("round_robin");
        for (int k = 0; k < 8; k++) begin
            vec++;
            if (obs_q.size() <= k || obs_q[k] !== {IW'(k / 2), k % 2 == 1, W'((k / 2) * 16 + k % 2)}) begin
                errs++; $display("FAIL rr_order: beat %0d got %h, required %h", k, obs_q[k], {IW'(k / 2), k % 2 == 1, W'((k / 2) * 16 + k % 2)});
            end
        end
    endtask

    task automatic test_burst_cap();
        clear_state();
        rdy_pct = 80;
        add_pkt(1, 10, 32'h100, 0);
        add_pkt(2, 3, 32'h200, 0);
        start();
        drain("burst_cap");
        for (int k = 0; k < 13; k++) begin
            int t;
            logic [W-1:0] d;
            t = (k >= 4 && k < 7) ? 2 : 1;
            d = t == 2 ? W'(32'h200 + k - 4) : W'(32'h100 + (k < 4 ? k : k - 3));
            vec++;
            if (obs_q.size() <= k || obs_q[k] !== {IW'(t), k == 3 || k == 6 || k == 10 || k == 12, d}) begin
                errs++; $display("FAIL burst_cap_order: beat %0d got %h, required %h", k, obs_q[k], {IW'(t), k == 3 || k == 6 || k == 10 || k == 12, d});
            end
        end
    endtask

    task automatic test_backpressure();
        clear_state();
        rdy_pct = 0;
        add_pkt(0, 6, '0, 1);
        start();
        repeat (6) @(negedge clk);
        #2;
        vec++;
        if (sp[0] != 2) begin errs++; $display("FAIL bp_buffered: %0d beats accepted, required 2", sp[0]); end
        vec++;
        if (s_in_tready !== '0 || m_out_tvalid !== 1'b1) begin
            errs++; $display("FAIL bp_ready: s_in_tready=%b m_out_tvalid=%b, required 0000 1", s_in_tready, m_out_tvalid);
        end
        vec++;
        if (m_out_tdata !== sd[0][0]) begin errs++; $display("FAIL bp_head: data=%h, required %h", m_out_tdata, sd[0][0]); end
        rdy_pct = 60;
        drain("backpressure");
    endtask

    task automatic test_mid_packet_stall();
        int c;
        clear_state();
        rdy_pct = 100;
        add_pkt(2, 3, '0, 1);
        add_pkt(3, 2, '0, 1);
        hold[2] = 5;
        start();
        c = 0;
        do begin @(negedge clk); #2; c++; end while (hold[2] == 5 && c < 50);
        vec++;
        if (hold[2] == 5) begin errs++; $display("FAIL stall_start: input 2 never mid-packet, required grant within 50 cycles"); end
        for (int k = 0; k < 5; k++) begin
            vec++;
            if (grant_idx !== 2'd2 || busy !== 1'b1 || s_in_tready[3] !== 1'b0 || (k > 0 && m_out_tvalid !== 1'b0)) begin
                errs++; $display("FAIL stall_hold: cycle %0d grant=%0d busy=%b ready3=%b valid=%b, required 2 1 0 0", k, grant_idx, busy, s_in_tready[3], m_out_tvalid);
            end
            @(negedge clk); #2;
        end
        drain("mid_stall");
        for (int k = 0; k < 5; k++) begin
            vec++;
            if (obs_q.size() <= k || obs_q[k][W+IW:W+1] !== IW'(k < 3 ? 2 : 3)) begin
                errs++; $display("FAIL stall_order: beat %0d tid=%0d, required %0d", k, obs_q[k][W+IW:W+1], k < 3 ? 2 : 3);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int c;
        clear_state();
        rdy_pct = 100;
        add_pkt(1, 2, '0, 1);
        add_pkt(2, 5, '0, 1);
        start();
        c = 0;
        do begin @(negedge clk); #2; c++; end while (sp[2] < 3 && c < 100);
        rst = 1; run_en = 0; s_in_tvalid = '0;
        @(negedge clk); #2;
        vec++;
        if (m_out_tvalid !== 1'b0 || busy !== 1'b0 || s_in_tready !== '0 || m_out_tdata !== '0 || m_out_tid !== '0 || m_out_tlast !== 1'b0) begin
            errs++; $display("FAIL midrst_clear: valid=%b busy=%b ready=%b data=%h, required 0 0 0000 0", m_out_tvalid, busy, s_in_tready, m_out_tdata);
        end
        rst = 0;
        model_ptr = 0;
        clear_state();
        add_pkt(0, 2, '0, 1);
        add_pkt(3, 2, '0, 1);
        start();
        drain("midrst");
        vec++;
        if (obs_q.size() == 0 || obs_q[0][W+IW:W+1] !== 2'd0) begin
            errs++; $display("FAIL midrst_first_grant: first tid=%0d, required 0", obs_q[0][W+IW:W+1]);
        end
    endtask

    task automatic test_random_traffic();
        clear_state();
        rdy_pct = 70; gap_pct = 25;
        for (int i = 0; i < N; i++) begin
            int np;
            np = int'($urandom_range(6, 3));
            for (int p = 0; p < np; p++) add_pkt(i, int'($urandom_range(7, 1)), '0, 1);
        end
        start();
        drain("random");
        gap_pct = 0;
    endtask

    initial begin
        s_in_tvalid = '0; s_in_tlast = '0; s_in_tdata = '0; m_out_tready = 1;
        clear_state();
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_mid_packet_stall();
        test_reset_mid_op();
        test_random_traffic();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end
endmodule
